// File: rtl/ah_packet_converter_w2n_15_5_pkg.sv
// Geometry shared by the wide<->narrow packet converters, plus a small
// width helper used to size counters and pointers.
package ah_pkt_pkg;

   localparam int WIDE_W      = 15;
   localparam int NARROW_W    = 5;
   localparam int LANES       = WIDE_W / NARROW_W;
   localparam int IN_DEPTH    = 2;
   localparam int OUT_CREDITS = 4;

   typedef logic [WIDE_W-1:0]   word_t;
   typedef logic [NARROW_W-1:0] beat_t;

   // Bits needed to index v distinct values, never less than one.
   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/ah_packet_converter_w2n_15_5_if.sv
// Wide-in / narrow-out credit bus between the converter and its neighbours.
interface ah_packet_converter_w2n_15_5_if;
   import ah_pkt_pkg::*;

   word_t wdata;
   logic  wvalid;
   logic  wcredit;
   beat_t rdata;
   logic  rvalid;
   logic  rcredit;
   logic  werr;

   modport master (
      output wdata, wvalid, rcredit,
      input  wcredit, rdata, rvalid, werr
   );

   modport slave (
      input  wdata, wvalid, rcredit,
      output wcredit, rdata, rvalid, werr
   );

endinterface

// File: rtl/ah_packet_converter_w2n_15_5_fifo.sv
// Small input buffer holding whole wide words; head is visible combinationally
// so the serializer can pick a lane in the same cycle it issues a beat.
module ah_pkt_fifo
   import ah_pkt_pkg::*;
#(
   parameter int DATA_W = WIDE_W,
   parameter int DEPTH  = IN_DEPTH
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] head,
   output logic              full,
   output logic              empty,
   output logic              last
);

   localparam int PTR_W = clog2_min1(DEPTH);
   localparam int CNT_W = clog2_min1(DEPTH + 1);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              do_push, do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign last  = (count_q == CNT_W'(1));
   assign head  = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
   end

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/ah_packet_converter_w2n_15_5.sv
// Wide-to-narrow converter: buffers wide words and serializes them MSB lane
// first onto a credit-controlled narrow beat stream.
module ah_packet_converter_w2n_15_5
   import ah_pkt_pkg::clog2_min1;
#(
   parameter int WIDE_W      = ah_pkt_pkg::WIDE_W,
   parameter int NARROW_W    = ah_pkt_pkg::NARROW_W,
   parameter int IN_DEPTH    = ah_pkt_pkg::IN_DEPTH,
   parameter int OUT_CREDITS = ah_pkt_pkg::OUT_CREDITS
) (
   input  logic                          clk,
   input  logic                          rstn,
   ah_packet_converter_w2n_15_5_if.slave bus
);

   localparam int LANES  = WIDE_W / NARROW_W;
   localparam int LANE_W = clog2_min1(LANES);
   localparam int CRED_W = clog2_min1(OUT_CREDITS + 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   logic [0:0]          state_q,   state_d;
   logic [LANE_W-1:0]   lane_q,    lane_d;
   logic [CRED_W-1:0]   credit_q,  credit_d;
   logic [NARROW_W-1:0] rdata_q,   rdata_d;
   logic                rvalid_q,  rvalid_d;
   logic                wcredit_q, wcredit_d;
   logic                werr_q,    werr_d;

   logic [WIDE_W-1:0]   head;
   logic [NARROW_W-1:0] lane_data [LANES];
   logic                fifo_full, fifo_empty, fifo_last;
   logic                issue, last_lane, pop, push;

   // Lane 0 is the most significant slice, matching the n2w collation order.
   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         assign lane_data[gi] = head[WIDE_W-1-gi*NARROW_W -: NARROW_W];
      end
   endgenerate

   assign last_lane = (lane_q == LANE_W'(LANES - 1));
   assign issue     = (state_q == ST_SEND) && !fifo_empty && (credit_q != '0);
   assign pop       = issue && last_lane;
   assign push      = bus.wvalid && (!fifo_full || pop);

   ah_pkt_fifo #(
      .DATA_W (WIDE_W),
      .DEPTH  (IN_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push),
      .pop   (pop),
      .wdata (bus.wdata),
      .head  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .last  (fifo_last)
   );

   always_comb begin
      state_d = state_q;
      if (push && !pop)                   state_d = ST_SEND;
      else if (pop && !push && fifo_last) state_d = ST_IDLE;

      lane_d = lane_q;
      if (issue) lane_d = last_lane ? '0 : lane_q + 1'b1;

      // A returned credit is dropped when the pool is already full.
      credit_d = credit_q;
      if (issue && !bus.rcredit)
         credit_d = credit_q - 1'b1;
      else if (!issue && bus.rcredit && (credit_q != CRED_W'(OUT_CREDITS)))
         credit_d = credit_q + 1'b1;

      rvalid_d  = issue;
      rdata_d   = issue ? lane_data[lane_q] : rdata_q;
      wcredit_d = pop;
      werr_d    = werr_q | (bus.wvalid && fifo_full && !pop);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= ST_IDLE;
         lane_q    <= '0;
         credit_q  <= CRED_W'(OUT_CREDITS);
         rdata_q   <= '0;
         rvalid_q  <= 1'b0;
         wcredit_q <= 1'b0;
         werr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         lane_q    <= lane_d;
         credit_q  <= credit_d;
         rdata_q   <= rdata_d;
         rvalid_q  <= rvalid_d;
         wcredit_q <= wcredit_d;
         werr_q    <= werr_d;
      end
   end

   assign bus.rdata   = rdata_q;
   assign bus.rvalid  = rvalid_q;
   assign bus.wcredit = wcredit_q;
   assign bus.werr    = werr_q;

endmodule

// File: tb/tb_ah_packet_converter_w2n_15_5.sv
// Directed bench for the wide-to-narrow converter: cycle-exact beat, credit
// and error checks with hand-computed expectations.
module tb_ah_packet_converter_w2n_15_5;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   ah_packet_converter_w2n_15_5_if bus ();

   ah_packet_converter_w2n_15_5 dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic beat(input string tag, input logic v, input logic [4:0] d, input logic wc);
      chk({tag, ".rvalid"}, 32'(bus.rvalid), 32'(v));
      if (v) chk({tag, ".rdata"}, 32'(bus.rdata), 32'(d));
      chk({tag, ".wcredit"}, 32'(bus.wcredit), 32'(wc));
   endtask

   task automatic push_word(input logic [14:0] w);
      bus.wdata  = w;
      bus.wvalid = 1'b1;
      $display("push word %h", w);
   endtask

   task automatic give(input int n);
      bus.rcredit = 1'b1;
      repeat (n) tick();
      bus.rcredit = 1'b0;
   endtask

   initial begin
      bus.wdata   = '0;
      bus.wvalid  = 1'b0;
      bus.rcredit = 1'b0;

      // Reset state
      rstn = 1'b0;
      repeat (2) tick();
      chk("rst.rvalid",  32'(bus.rvalid),  32'(0));
      chk("rst.rdata",   32'(bus.rdata),   32'(0));
      chk("rst.wcredit", 32'(bus.wcredit), 32'(0));
      chk("rst.werr",    32'(bus.werr),    32'(0));
      chk("rst.credit",  32'(dut.credit_q), 32'(4));
      rstn = 1'b1;
      tick();

      // Single word 5A3C: lanes 16, 11, 1C at N+2..N+4
      push_word(15'h5A3C);
      tick();
      bus.wvalid = 1'b0;
      beat("t1.n1", 1'b0, 5'h00, 1'b0); tick();
      beat("t1.n2", 1'b1, 5'h16, 1'b0); tick();
      beat("t1.n3", 1'b1, 5'h11, 1'b0); tick();
      beat("t1.n4", 1'b1, 5'h1C, 1'b1); tick();
      beat("t1.n5", 1'b0, 5'h00, 1'b0);
      chk("t1.credit", 32'(dut.credit_q), 32'(1));
      give(3);
      chk("t1.refill", 32'(dut.credit_q), 32'(4));

      // Credit return at full pool is ignored
      give(2);
      tick();
      chk("sat.credit", 32'(dut.credit_q), 32'(4));
      beat("sat.idle", 1'b0, 5'h00, 1'b0);

      // Two words, no returns: four beats then stall; one credit -> one beat
      push_word({5'h01, 5'h02, 5'h03});
      tick();
      push_word({5'h04, 5'h05, 5'h06});
      beat("t2.n1", 1'b0, 5'h00, 1'b0); tick();
      bus.wvalid = 1'b0;
      beat("t2.n2", 1'b1, 5'h01, 1'b0); tick();
      beat("t2.n3", 1'b1, 5'h02, 1'b0); tick();
      beat("t2.n4", 1'b1, 5'h03, 1'b1); tick();
      beat("t2.n5", 1'b1, 5'h04, 1'b0); tick();
      beat("t2.n6", 1'b0, 5'h00, 1'b0); tick();
      beat("t2.n7", 1'b0, 5'h00, 1'b0);
      chk("t2.credit0", 32'(dut.credit_q), 32'(0));
      bus.rcredit = 1'b1;
      tick();
      bus.rcredit = 1'b0;
      beat("t2.m1", 1'b0, 5'h00, 1'b0); tick();
      beat("t2.m2", 1'b1, 5'h05, 1'b0); tick();
      beat("t2.m3", 1'b0, 5'h00, 1'b0);
      bus.rcredit = 1'b1;
      tick();
      bus.rcredit = 1'b0;
      beat("t2.m4", 1'b0, 5'h00, 1'b0); tick();
      beat("t2.m5", 1'b1, 5'h06, 1'b1); tick();
      beat("t2.m6", 1'b0, 5'h00, 1'b0);
      give(4);
      chk("t2.refill", 32'(dut.credit_q), 32'(4));

      // Beat and return in the same cycle at credit 1: no bubble
      push_word({5'h07, 5'h08, 5'h09});
      tick();
      push_word({5'h0A, 5'h0B, 5'h0C});
      tick();
      bus.wvalid = 1'b0;
      beat("t3.n2", 1'b1, 5'h07, 1'b0); tick();
      beat("t3.n3", 1'b1, 5'h08, 1'b0); tick();
      beat("t3.n4", 1'b1, 5'h09, 1'b1);
      chk("t3.credit1", 32'(dut.credit_q), 32'(1));
      bus.rcredit = 1'b1;
      tick();
      beat("t3.n5", 1'b1, 5'h0A, 1'b0);
      chk("t3.hold", 32'(dut.credit_q), 32'(1));
      tick();
      beat("t3.n6", 1'b1, 5'h0B, 1'b0); tick();
      bus.rcredit = 1'b0;
      beat("t3.n7", 1'b1, 5'h0C, 1'b1);
      chk("t3.end", 32'(dut.credit_q), 32'(1));
      tick();
      beat("t3.n8", 1'b0, 5'h00, 1'b0);
      give(3);
      chk("t3.refill", 32'(dut.credit_q), 32'(4));

      // Third word into a full buffer is dropped and flags werr
      bus.rcredit = 1'b1;
      push_word({5'h11, 5'h12, 5'h13});
      tick();
      push_word({5'h14, 5'h15, 5'h16});
      beat("t4.n1", 1'b0, 5'h00, 1'b0); tick();
      push_word({5'h1F, 5'h1F, 5'h1F});
      beat("t4.n2", 1'b1, 5'h11, 1'b0);
      chk("t4.werr0", 32'(bus.werr), 32'(0));
      tick();
      bus.wvalid = 1'b0;
      beat("t4.n3", 1'b1, 5'h12, 1'b0);
      chk("t4.werr1", 32'(bus.werr), 32'(1));
      tick();
      beat("t4.n4", 1'b1, 5'h13, 1'b1); tick();
      beat("t4.n5", 1'b1, 5'h14, 1'b0); tick();
      beat("t4.n6", 1'b1, 5'h15, 1'b0); tick();
      bus.rcredit = 1'b0;
      beat("t4.n7", 1'b1, 5'h16, 1'b1); tick();
      beat("t4.n8", 1'b0, 5'h00, 1'b0);
      chk("t4.sticky", 32'(bus.werr), 32'(1));
      chk("t4.credit", 32'(dut.credit_q), 32'(4));

      // Reset after lane1 discards the word; next word starts at lane0
      push_word({5'h01, 5'h1E, 5'h0F});
      tick();
      bus.wvalid = 1'b0;
      beat("t5.n1", 1'b0, 5'h00, 1'b0); tick();
      beat("t5.n2", 1'b1, 5'h01, 1'b0); tick();
      beat("t5.n3", 1'b1, 5'h1E, 1'b0);
      rstn = 1'b0;
      #1;
      beat("t5.rst", 1'b0, 5'h00, 1'b0);
      chk("t5.rdata",  32'(bus.rdata),    32'(0));
      chk("t5.werr",   32'(bus.werr),     32'(0));
      chk("t5.credit", 32'(dut.credit_q), 32'(4));
      tick();
      beat("t5.hold", 1'b0, 5'h00, 1'b0);
      rstn = 1'b1;
      tick();
      beat("t5.rel1", 1'b0, 5'h00, 1'b0); tick();
      beat("t5.rel2", 1'b0, 5'h00, 1'b0);
      push_word({5'h1A, 5'h02, 5'h1B});
      tick();
      bus.wvalid = 1'b0;
      beat("t5.m1", 1'b0, 5'h00, 1'b0); tick();
      beat("t5.m2", 1'b1, 5'h1A, 1'b0); tick();
      beat("t5.m3", 1'b1, 5'h02, 1'b0); tick();
      beat("t5.m4", 1'b1, 5'h1B, 1'b1); tick();
      beat("t5.m5", 1'b0, 5'h00, 1'b0);
      chk("t5.credit1", 32'(dut.credit_q), 32'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ah_packet_converter_w2n_15_5.md
AH_PACKET_CONVERTER_W2N_15_5 -- requirements
Module: ah_packet_converter_w2n_15_5

Interface
REQ-001 SHALL have parameter WIDE_W, default 15, wide packet width.
REQ-002 SHALL have parameter NARROW_W, default 5, narrow beat width; LANES = WIDE_W/NARROW_W = 3.
REQ-003 SHALL have parameter IN_DEPTH, default 2, input buffer depth in wide words.
REQ-004 SHALL have parameter OUT_CREDITS, default 4, downstream credits held at reset.
REQ-005 Clocking is decided: one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  the single clock.
REQ-007 rstn  input  1  asynchronous active-low reset.
REQ-008 wdata  input  15  wide packet from the upstream n2w converter.
REQ-009 wvalid  input  1  wdata valid; upstream asserts it only while holding a credit.
REQ-010 wcredit  output  1  one-cycle pulse returning one input-buffer credit.
REQ-011 rdata  output  5  narrow beat.
REQ-012 rvalid  output  1  rdata valid, one beat per cycle.
REQ-013 rcredit  input  1  one-cycle pulse returning one downstream credit.
REQ-014 werr  output  1  sticky overflow flag.

Function
REQ-015 SHALL write wdata into the IN_DEPTH FIFO when wvalid=1 and the FIFO is not full, or is full and popping in the same cycle.
REQ-016 SHALL drop wvalid data arriving when the FIFO is full with no pop, set werr, and leave stored words unchanged.
REQ-017 SHALL serialize each word MSB lane first: lane0=[14:10], lane1=[9:5], lane2=[4:0], matching n2w collation order.
REQ-018 FSM: IDLE (FIFO empty) and SEND; 2-bit lane counter runs 0->1->2 and wraps to 0.
REQ-019 SHALL issue a beat in cycle k when the FIFO is non-empty and credit_cnt>0; rdata/rvalid are registered and appear in cycle k+1.
REQ-020 SHALL keep rvalid=0 in any cycle with no beat issued; rdata holds its last value.
REQ-021 SHALL pop the FIFO on the edge issuing lane2; wcredit SHALL be registered on that edge, so it is high in the same cycle as the lane2 rvalid.
REQ-022 Back-to-back words SHALL stream without bubbles while credits last; lane2 of word n is followed by lane0 of word n+1.
REQ-023 Latency: wvalid in cycle N -> lane0 rvalid in cycle N+2 when the FIFO was empty and credit_cnt>0.
REQ-024 credit_cnt: decrement per beat issued; increment per rcredit; both in one cycle -> unchanged.
REQ-025 SHALL ignore rcredit with credit_cnt=OUT_CREDITS and no beat issued; the count saturates and never wraps.
REQ-026 A credit returned in cycle M with credit_cnt=0 SHALL produce a beat with rvalid in cycle M+2.
REQ-027 Stalling mid-word SHALL hold the lane counter and FIFO head; resume SHALL continue at the next lane.

Reset
REQ-028 On rstn=0: FIFO empty, lane=0, FSM=IDLE, credit_cnt=OUT_CREDITS, rvalid=0, rdata=0, wcredit=0, werr=0.
REQ-029 Reset mid-word SHALL discard the partial word with no wcredit pulse; the first word after reset starts at lane0.

Structure
REQ-030 Package ah_pkt_pkg SHALL hold WIDE_W, NARROW_W, LANES, IN_DEPTH and OUT_CREDITS constants shared with the n2w converter.
REQ-031 The input buffer SHALL be sub-module ah_pkt_fifo (push, pop, full, empty, head data).

Verification
REQ-032 Single word 15'h5A3C in cycle N -> rvalid in N+2..N+4 with rdata 5'h16, 5'h11, 5'h1C; wcredit high in N+4 only.
REQ-033 Two words, no rcredit -> exactly 4 beats, then rvalid=0; one rcredit in cycle M -> one beat (lane1 of word 2) in M+2.
REQ-034 credit_cnt=1, beat issued with rcredit in the same cycle -> count stays 1, stream continues without a bubble.
REQ-035 Three wvalid with no wcredit between them -> third word dropped, werr=1, words 1 and 2 output intact (6 beats).
REQ-036 rstn low after lane1 of a word -> rvalid=0, no wcredit, credit_cnt=4; next word emits lane0 first.
